// File: rtl/memory_pkg.sv
// Shared memory-subsystem types for the store write buffer: request/response
// structs, entry storage format, drain-state encoding and byte-range helpers.
package memory_pkg;

    localparam int ROB_W = 6;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_addr;
        logic [63:0]      addr;
        logic [63:0]      data;
        msize_t           msize;
    } wbuffer_wreq_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_addr;
    } wbuffer_creq_t;

    typedef struct packed {
        logic [ROB_W-1:0] rob_addr;
        logic [63:0]      addr;
        logic [63:0]      data;
        msize_t           msize;
    } wbuffer_entry_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      msize;
    } wbuffer_rreq_t;

    typedef struct packed {
        logic        hit;
        logic        stall;
        logic [63:0] data;
    } wbuffer_rresp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [63:0] data;
        msize_t      msize;
    } wbuffer_dreq_t;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

    // Byte count of an access, widened so end addresses never overflow.
    function automatic logic [64:0] msize_bytes(msize_t m);
        return 65'd1 << m;
    endfunction

    // Mask keeping only the low bytes a load of size m returns.
    function automatic logic [63:0] msize_mask(msize_t m);
        case (m)
            MSIZE_B: return 64'h0000_0000_0000_00ff;
            MSIZE_H: return 64'h0000_0000_0000_ffff;
            MSIZE_W: return 64'h0000_0000_ffff_ffff;
            default: return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    // True when byte ranges [sa, sa+bytes(sm)) and [la, la+bytes(lm)) intersect.
    function automatic logic ranges_overlap(logic [63:0] sa, msize_t sm, logic [63:0] la, msize_t lm);
        return ({1'b0, la} < ({1'b0, sa} + msize_bytes(sm))) &&
               ({1'b0, sa} < ({1'b0, la} + msize_bytes(lm)));
    endfunction

    // True when the store range fully contains the load range.
    function automatic logic range_covers(logic [63:0] sa, msize_t sm, logic [63:0] la, msize_t lm);
        return ({1'b0, la} >= {1'b0, sa}) &&
               (({1'b0, la} + msize_bytes(lm)) <= ({1'b0, sa} + msize_bytes(sm)));
    endfunction

endpackage

// File: rtl/store_wbuffer_chk.sv
// Simulation checker: a commit must always name the oldest speculative store.
module store_wbuffer_chk (
    input logic clk,
    input logic reset,
    input logic creq_valid,
    input logic spec_nonempty,
    input logic rob_match
);

    a_commit_legal: assert property (@(posedge clk) disable iff (reset)
        creq_valid |-> (spec_nonempty && rob_match));

endmodule

// File: rtl/wbuffer_fwd.sv
// Store-to-load forwarding unit: scans the live entries oldest to youngest,
// keeps the youngest overlapping store and decides hit / stall / data.
// Build option WBUFFER_FWD_EN enables forwarding; without it any overlap stalls.
module wbuffer_fwd
    import memory_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  wbuffer_entry_t entries [DEPTH],
    input  logic [PW-1:0]  head,
    input  logic [PW-1:0]  tail,
    input  wbuffer_rreq_t  rreq,
    output wbuffer_rresp_t rresp
);

    logic [PW-1:0] count_s;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          cov_s;
    logic [63:0]   off_s;
    logic [63:0]   fdata_s;
    logic          unused_bits;

    // Youngest-match search; later (younger) entries overwrite earlier results.
    always_comb begin
        count_s = tail - head;
        idx_s   = '0;
        found_s = 1'b0;
        cov_s   = 1'b0;
        off_s   = 64'd0;
        fdata_s = 64'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head[IW-1:0] + IW'(k);
            if ((PW'(k) < count_s) &&
                ranges_overlap(entries[idx_s].addr, entries[idx_s].msize, rreq.addr, rreq.msize)) begin
                found_s = 1'b1;
                cov_s   = range_covers(entries[idx_s].addr, entries[idx_s].msize, rreq.addr, rreq.msize);
                off_s   = rreq.addr - entries[idx_s].addr;
                fdata_s = (entries[idx_s].data >> {off_s[2:0], 3'b000}) & msize_mask(rreq.msize);
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef WBUFFER_FWD_EN
    // Full coverage forwards aligned data; partial overlap forces a replay.
    always_comb begin
        rresp.hit   = rreq.valid & found_s & cov_s;
        rresp.stall = rreq.valid & found_s & ~cov_s;
        if (rreq.valid & found_s & cov_s) begin
            rresp.data = fdata_s;
        end else begin
            rresp.data = 64'd0;
        end
    end

    // Fields that do not take part in forwarding.
    always_comb begin
        unused_bits = ^off_s;
        for (int k = 0; k < DEPTH; k++) begin
            unused_bits = unused_bits ^ (^entries[k].rob_addr);
        end
    end
`else
    // Forwarding disabled: any overlap makes the load wait for the drain.
    always_comb begin
        rresp.hit   = 1'b0;
        rresp.stall = rreq.valid & found_s;
        rresp.data  = 64'd0;
    end

    // Fields that do not take part when forwarding is disabled.
    always_comb begin
        unused_bits = (^off_s) ^ (^fdata_s) ^ cov_s;
        for (int k = 0; k < DEPTH; k++) begin
            unused_bits = unused_bits ^ (^entries[k].rob_addr);
        end
    end
`endif

endmodule

// File: rtl/store_wbuffer.sv
// Post-execute store write buffer: speculative push, in-order commit, one-at-a-time
// drain to the D-cache, flush of uncommitted entries and store-to-load forwarding.
// Build option WBUFFER_FWD_EN selects forwarding (see wbuffer_fwd).
module store_wbuffer
    import memory_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  wbuffer_wreq_t wreq,
    output logic          wreq_ready,
    input  wbuffer_creq_t creq,
    input  logic          flush,
    input  logic          rreq_valid,
    input  logic [63:0]   rreq_addr,
    input  msize_t        rreq_msize,
    output logic          rresp_hit,
    output logic [63:0]   rresp_data,
    output logic          rresp_stall,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output logic [63:0]   dreq_data,
    output msize_t        dreq_msize,
    input  logic          dresp_ack,
    output logic          empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    wbuffer_entry_t entries_r [DEPTH];
    logic [PW-1:0]  head_r;
    logic [PW-1:0]  commit_ptr_r;
    logic [PW-1:0]  tail_r;
    logic [PW-1:0]  commit_nxt_s;
    wb_state_t      state_r;
    wbuffer_dreq_t  dreq_r;

    logic full_s;
    logic push_fire_s;
    logic spec_nonempty_s;
    logic rob_match_s;
    logic commit_fire_s;
    logic pop_fire_s;

    wbuffer_rreq_t  rreq_s;
    wbuffer_rresp_t rresp_s;

    assign full_s          = (tail_r - head_r) == PW'(DEPTH);
    assign push_fire_s     = wreq.valid & ~full_s & ~flush;
    assign spec_nonempty_s = (commit_ptr_r != tail_r);
    assign rob_match_s     = (entries_r[commit_ptr_r[IW-1:0]].rob_addr == creq.rob_addr);
    assign commit_fire_s   = creq.valid & spec_nonempty_s & rob_match_s;
    assign commit_nxt_s    = commit_ptr_r + PW'(commit_fire_s);
    assign pop_fire_s      = (state_r == WB_REQ) & dresp_ack;

    // Pointer bookkeeping; flush rewinds tail onto the post-commit boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= '0;
            commit_ptr_r <= '0;
            tail_r       <= '0;
        end else begin
            head_r       <= head_r + PW'(pop_fire_s);
            commit_ptr_r <= commit_nxt_s;
            if (flush) begin
                tail_r <= commit_nxt_s;
            end else begin
                tail_r <= tail_r + PW'(push_fire_s);
            end
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            entries_r[tail_r[IW-1:0]] <= '{rob_addr: wreq.rob_addr, addr: wreq.addr,
                                           data: wreq.data, msize: wreq.msize};
        end
    end

    // Drain FSM; a same-cycle commit at the head starts the request a cycle early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WB_IDLE;
            dreq_r  <= '0;
        end else begin
            case (state_r)
                WB_IDLE: begin
                    if ((head_r != commit_ptr_r) || commit_fire_s) begin
                        state_r <= WB_REQ;
                        dreq_r  <= '{valid: 1'b1, addr: entries_r[head_r[IW-1:0]].addr,
                                     data: entries_r[head_r[IW-1:0]].data,
                                     msize: entries_r[head_r[IW-1:0]].msize};
                    end else begin
                        dreq_r.valid <= 1'b0;
                    end
                end
                WB_REQ: begin
                    if (dresp_ack) begin
                        state_r      <= WB_IDLE;
                        dreq_r.valid <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= WB_IDLE;
                    dreq_r.valid <= 1'b0;
                end
            endcase
        end
    end

    assign rreq_s = '{valid: rreq_valid, addr: rreq_addr, msize: rreq_msize};

    wbuffer_fwd #(.DEPTH(DEPTH)) u_fwd (
        .entries (entries_r),
        .head    (head_r),
        .tail    (tail_r),
        .rreq    (rreq_s),
        .rresp   (rresp_s)
    );

    store_wbuffer_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .creq_valid    (creq.valid),
        .spec_nonempty (spec_nonempty_s),
        .rob_match     (rob_match_s)
    );

    assign wreq_ready  = ~full_s;
    assign empty       = (head_r == tail_r);
    assign dreq_valid  = dreq_r.valid;
    assign dreq_addr   = dreq_r.addr;
    assign dreq_data   = dreq_r.data;
    assign dreq_msize  = dreq_r.msize;
    assign rresp_hit   = rresp_s.hit;
    assign rresp_stall = rresp_s.stall;
    assign rresp_data  = rresp_s.data;

endmodule

// File: tb/tb_store_wbuffer.sv
// Bench for store_wbuffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_store_wbuffer;
    import memory_pkg::*;

    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    wbuffer_wreq_t wreq;
    logic          wreq_ready;
    wbuffer_creq_t creq;
    logic          flush;
    logic          rreq_valid;
    logic [63:0]   rreq_addr;
    msize_t        rreq_msize;
    logic          rresp_hit;
    logic [63:0]   rresp_data;
    logic          rresp_stall;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    logic [63:0]   dreq_data;
    msize_t        dreq_msize;
    logic          dresp_ack;
    logic          empty;

    int n_vec = 0;
    int n_err = 0;

    store_wbuffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wreq(wreq), .wreq_ready(wreq_ready), .creq(creq),
        .flush(flush), .rreq_valid(rreq_valid), .rreq_addr(rreq_addr), .rreq_msize(rreq_msize),
        .rresp_hit(rresp_hit), .rresp_data(rresp_data), .rresp_stall(rresp_stall),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_data(dreq_data),
        .dreq_msize(dreq_msize), .dresp_ack(dresp_ack), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    wbuffer_entry_t q[$];
    int  ncom = 0;     // number of committed entries at the front of q
    bit  m_dv = 0;     // a drain request is outstanding
    bit  live = 0;
    bit  m_full, m_pop, m_cm;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            ncom = 0;
            m_dv = 0;
            live = 1;
        end else if (live) begin
            m_full = (q.size() == DEPTH);
            m_pop  = m_dv && dresp_ack;
            m_cm   = creq.valid && (ncom < q.size()) && (q[ncom].rob_addr == creq.rob_addr);
            if (m_cm) ncom++;
            if (m_pop) begin
                void'(q.pop_front());
                ncom--;
                m_dv = 0;
            end else if (!m_dv && ncom > 0) begin
                m_dv = 1;
            end
            if (flush) begin
                while (q.size() > ncom) void'(q.pop_back());
            end else if (wreq.valid && !m_full) begin
                q.push_back('{rob_addr: wreq.rob_addr, addr: wreq.addr,
                              data: wreq.data, msize: wreq.msize});
            end
        end
    end

    function automatic void model_fwd(output logic h, output logic s, output logic [63:0] d);
        int y;
        int lb, sb;
        longint unsigned sa, la;
        bit cov;
        h = 1'b0; s = 1'b0; d = 64'd0; y = -1;
        if (rreq_valid) begin
            lb = 1 << int'(rreq_msize);
            for (int i = 0; i < q.size(); i++) begin
                sa = q[i].addr;
                sb = 1 << int'(q[i].msize);
                for (int b = 0; b < lb; b++) begin
                    la = rreq_addr + longint'(b);
                    if (la >= sa && la < sa + longint'(sb)) y = i;
                end
            end
            if (y >= 0) begin
                sa  = q[y].addr;
                sb  = 1 << int'(q[y].msize);
                cov = 1'b1;
                for (int b = 0; b < lb; b++) begin
                    la = rreq_addr + longint'(b);
                    if (la >= sa && la < sa + longint'(sb))
                        d[8*b +: 8] = q[y].data[8*int'(la - sa) +: 8];
                    else
                        cov = 1'b0;
                end
`ifdef WBUFFER_FWD_EN
                h = cov;
                s = !cov;
                if (!cov) d = 64'd0;
`else
                s = 1'b1;
                d = 64'd0;
`endif
            end
        end
    endfunction

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic eh, es;
        logic [63:0] ed;
        if (live) begin
            chk("wreq_ready", wreq_ready, (q.size() < DEPTH) ? 64'd1 : 64'd0);
            chk("empty", empty, (q.size() == 0) ? 64'd1 : 64'd0);
            chk("dreq_valid", dreq_valid, m_dv ? 64'd1 : 64'd0);
            if (m_dv) begin
                chk("dreq_addr", dreq_addr, q[0].addr);
                chk("dreq_data", dreq_data, q[0].data);
                chk("dreq_msize", 64'(dreq_msize), 64'(q[0].msize));
            end
            model_fwd(eh, es, ed);
            chk("rresp_hit", rresp_hit, 64'(eh));
            chk("rresp_stall", rresp_stall, 64'(es));
            chk("rresp_data", rresp_data, ed);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] rob, input logic [63:0] a, input logic [63:0] d, input msize_t m);
        wreq = '{valid: 1'b1, rob_addr: rob, addr: a, data: d, msize: m};
        tick();
        wreq = '0;
    endtask

    task automatic commit(input logic [5:0] rob);
        creq = '{valid: 1'b1, rob_addr: rob};
        tick();
        creq = '0;
    endtask

    task automatic drain_until_empty(input int budget);
        int n;
        n = 0;
        while (!empty && n < budget) begin
            dresp_ack = dreq_valid;
            tick();
            n++;
        end
        dresp_ack = 1'b0;
        chk("drain_empty", empty, 64'd1);
    endtask

    task automatic load(input logic [63:0] a, input msize_t m);
        rreq_valid = 1'b1;
        rreq_addr  = a;
        rreq_msize = m;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wreq = '0; creq = '0; flush = 1'b0; dresp_ack = 1'b0;
        rreq_valid = 1'b0; rreq_addr = 64'd0; rreq_msize = MSIZE_B;
        tick(); tick();
        reset = 1'b0;
        chk("reset_ready", wreq_ready, 64'd1);
        chk("reset_empty", empty, 64'd1);
        chk("reset_dv", dreq_valid, 64'd0);

        // 1: single store, commit, ack after 3 cycles
        push(6'd1, 64'h8000_0000, 64'h1122_3344_5566_7788, MSIZE_D);
        commit(6'd1);
        chk("t1_dv_c1", dreq_valid, 64'd1);
        chk("t1_addr", dreq_addr, 64'h8000_0000);
        chk("t1_data", dreq_data, 64'h1122_3344_5566_7788);
        tick();
        chk("t1_dv_c2", dreq_valid, 64'd1);
        tick();
        chk("t1_dv_c3", dreq_valid, 64'd1);
        dresp_ack = 1'b1;
        tick();
        dresp_ack = 1'b0;
        chk("t1_dv_done", dreq_valid, 64'd0);
        chk("t1_empty", empty, 64'd1);

        // 2: fill, overflow push dropped, one drain reopens
        for (int i = 0; i < DEPTH; i++)
            push(6'(10 + i), 64'h1000 + 64'(8 * i), 64'hA000 + 64'(i), MSIZE_D);
        chk("t2_full", wreq_ready, 64'd0);
        push(6'd18, 64'h2000, 64'hBAD, MSIZE_D);
        chk("t2_still_full", wreq_ready, 64'd0);
        commit(6'd10);
        chk("t2_dv", dreq_valid, 64'd1);
        chk("t2_head_addr", dreq_addr, 64'h1000);
        dresp_ack = 1'b1;
        tick();
        dresp_ack = 1'b0;
        chk("t2_ready_back", wreq_ready, 64'd1);
        for (int i = 1; i < DEPTH; i++) commit(6'(10 + i));
        drain_until_empty(200);

        // 3: commit A, flush B
        push(6'd3, 64'h200, 64'hAAAA, MSIZE_D);
        push(6'd4, 64'h208, 64'hBBBB, MSIZE_D);
        commit(6'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_dv", dreq_valid, 64'd1);
        chk("t3_addr", dreq_addr, 64'h200);
        dresp_ack = 1'b1;
        tick();
        dresp_ack = 1'b0;
        tick(); tick(); tick();
        chk("t3_no_b", dreq_valid, 64'd0);
        chk("t3_empty", empty, 64'd1);
        // 3b: commit, flush and push in the same cycle
        push(6'd5, 64'h300, 64'hCCCC, MSIZE_D);
        push(6'd6, 64'h308, 64'hDDDD, MSIZE_D);
        creq  = '{valid: 1'b1, rob_addr: 6'd5};
        flush = 1'b1;
        wreq  = '{valid: 1'b1, rob_addr: 6'd7, addr: 64'h310, data: 64'hEEEE, msize: MSIZE_D};
        tick();
        creq = '0; flush = 1'b0; wreq = '0;
        chk("t3b_dv", dreq_valid, 64'd1);
        chk("t3b_addr", dreq_addr, 64'h300);
        drain_until_empty(50);

        // 4: forwarding from a word store
        push(6'd20, 64'h100, 64'hdead_beef, MSIZE_W);
        load(64'h102, MSIZE_B);
`ifdef WBUFFER_FWD_EN
        chk("t4_hit", rresp_hit, 64'd1);
        chk("t4_data", rresp_data, 64'had);
        chk("t4_stall_b", rresp_stall, 64'd0);
`else
        chk("t4_hit", rresp_hit, 64'd0);
        chk("t4_stall_b", rresp_stall, 64'd1);
`endif
        load(64'h100, MSIZE_D);
        chk("t4_stall_d", rresp_stall, 64'd1);
        chk("t4_hit_d", rresp_hit, 64'd0);
        load(64'h104, MSIZE_B);
        chk("t4_miss_hit", rresp_hit, 64'd0);
        chk("t4_miss_stall", rresp_stall, 64'd0);
        rreq_valid = 1'b0;

        // 5: youngest store wins
        push(6'd21, 64'h100, 64'h11, MSIZE_B);
        push(6'd22, 64'h100, 64'h22, MSIZE_B);
        load(64'h100, MSIZE_B);
`ifdef WBUFFER_FWD_EN
        chk("t5_hit", rresp_hit, 64'd1);
        chk("t5_data", rresp_data, 64'h22);
`else
        chk("t5_stall", rresp_stall, 64'd1);
`endif
        load(64'h100, MSIZE_H);
        chk("t5_partial", rresp_stall, 64'd1);
        rreq_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flushed", empty, 64'd1);

        // 6: reset during an outstanding drain request
        push(6'd30, 64'h400, 64'h4444, MSIZE_D);
        commit(6'd30);
        chk("t6_dv", dreq_valid, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_dv", dreq_valid, 64'd0);
        chk("t6_empty", empty, 64'd1);
        chk("t6_ready", wreq_ready, 64'd1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
